// File: rtl/ckgate_ctrl_pkg.sv
// Shared types for the clock-enable controller: the FSM state encoding
// and the helper that sizes the shared IDLE/WAKE counter.
package ckgate_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        IDLE  = 3'd1,
        DRAIN = 3'd2,
        OFF   = 3'd3,
        WAKE  = 3'd4
    } state_t;

    // One counter serves both the idle window and the wake window.
    function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
        int m;
        m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ckgate_ctrl_retime.sv
// Falling-edge flop that launches the clock-gate enable, so E only moves
// while CK is low. Synchronous active-low reset forces the clock on.
module ckgate_ctrl_retime (
    input  logic CK,
    input  logic RN,
    input  logic i_e_nxt,
    output logic o_e
);

    logic r_e;

    // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside the
    // clocked branch instead of the sensitivity list.
    always_ff @(negedge CK) begin
        if (!RN) begin
            r_e <= 1'b1;
        end else begin
            r_e <= i_e_nxt;
        end
    end

    assign o_e = r_e;

endmodule

// File: rtl/ckgate_ctrl.sv
// Clock-enable controller: idle window, sleep handshake, wake sequencing.
// Optional stopped-cycle counter is built when CKGATE_CTRL_STATS_EN is defined.
module ckgate_ctrl
    import ckgate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        CK,
    input  logic        RN,
    input  logic        TE,
    input  logic        busy,
    input  logic        wake_req,
    input  logic        sleep_ack,
    output logic        sleep_req,
    output logic        E,
    output logic        clk_ready
`ifdef CKGATE_CTRL_STATS_EN
    ,
    output logic [15:0] gated_cycles
`endif
);

    localparam int CW = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_wake;
    logic            w_e_nxt;

    assign w_wake = wake_req | TE;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (!busy && !w_wake) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = CW'(1);
                end
            end
            IDLE: begin
                if (busy || w_wake) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == IDLE_LAST) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            DRAIN: begin
                // Activity or a wake request takes priority over the acknowledge.
                if (busy || w_wake) begin
                    w_state_nxt = RUN;
                end else if (sleep_ack) begin
                    w_state_nxt = OFF;
                end
            end
            OFF: begin
                if (w_wake) begin
                    w_state_nxt = WAKE;
                    w_cnt_nxt   = '0;
                end
            end
            WAKE: begin
                if (r_cnt == WAKE_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge CK) begin
        if (!RN) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign sleep_req = (r_state == DRAIN);
    assign clk_ready = (r_state == RUN) || (r_state == IDLE) || (r_state == DRAIN);
    assign w_e_nxt   = (r_state != OFF);

    ckgate_ctrl_retime u_retime (
        .CK      (CK),
        .RN      (RN),
        .i_e_nxt (w_e_nxt),
        .o_e     (E)
    );

`ifdef CKGATE_CTRL_STATS_EN
    logic [15:0] r_gated;

    always_ff @(posedge CK) begin
        if (!RN) begin
            r_gated <= '0;
        end else if ((r_state == OFF) && (r_gated != 16'hFFFF)) begin
            r_gated <= r_gated + 16'd1;
        end
    end

    assign gated_cycles = r_gated;
`endif

endmodule

// File: doc/ckgate_ctrl.md
# ckgate_ctrl

Clock-enable controller that sits directly upstream of the clock-gating cell and drives its `E` input. It runs on the free-running clock and watches an activity indication from the gated domain. After a programmable idle window it performs a sleep request/acknowledge handshake with the gated domain, then drops `E`. On a wake request it restores `E` and signals when the gated domain's clock is stable again. `E` is retimed to the falling edge of `CK` so that it only changes while `CK` is low, because the gate cell has no internal latch.

## Interface
- `IDLE_CYCLES`, 16: consecutive idle samples required before a sleep request. Must be ≥2.
- `WAKE_CYCLES`, 2: cycles spent in WAKE before `clk_ready` returns. Must be ≥1.
- `CK` in 1: free-running input clock, the same clock fed to the gate cell.
- `RN` in 1: reset. Synchronous, active-low.
- `TE` in 1: test enable. Forces the controller awake.
- `busy` in 1: activity from the gated domain. High means not idle.
- `wake_req` in 1: wake request from an ungated source.
- `sleep_ack` in 1: gated domain has quiesced and accepts clock stop.
- `sleep_req` out 1: sleep request to the gated domain.
- `E` out 1: enable to the clock gate. Launched on the falling edge.
- `clk_ready` out 1: the gated clock is running and stable.
- `gated_cycles` out 16: count of stopped-clock cycles. Present only with `CKGATE_CTRL_STATS_EN`.

## Operation
- States: RUN, IDLE, DRAIN, OFF, WAKE.
- `sleep_req` and `clk_ready` are decoded directly from the state register, with no extra flop:
  - `sleep_req` = DRAIN.
  - `clk_ready` = RUN, IDLE or DRAIN.
- `e_nxt` = (state ≠ OFF). It is captured into `E` at the falling edge of `CK`.
- Define `wake` = `wake_req` | `TE`.
- RUN:
  - If `busy`=0 and `wake`=0, go to IDLE with cnt=1. Otherwise stay.
- IDLE:
  - If `busy` or `wake`, go to RUN and clear cnt.
  - Else if cnt = IDLE_CYCLES−1, go to DRAIN.
  - Else increment cnt.
  - DRAIN is therefore entered on the IDLE_CYCLES-th consecutive idle sample.
- DRAIN:
  - `busy` or `wake` aborts: go to RUN. The abort wins over a simultaneous `sleep_ack`.
  - Else if `sleep_ack`, go to OFF.
  - Otherwise wait indefinitely; there is no timeout.
- OFF:
  - If `wake`, go to WAKE with cnt=0. `busy` is ignored in OFF, since the gated domain cannot change it.
- WAKE:
  - Increment cnt each cycle.
  - When cnt = WAKE_CYCLES−1, go to RUN.
- cnt width is $clog2(max(IDLE_CYCLES, WAKE_CYCLES)+1). It is a single counter shared by IDLE and WAKE.
- Reset (`RN`=0 sampled at a rising edge):
  - State goes to RUN and cnt to 0.
  - `E` flop sets to 1 at the falling edge where `RN`=0 is sampled.
  - Reset in any state, including OFF, restores the clock.
- Reset values: `E`=1, `clk_ready`=1, `sleep_req`=0, `gated_cycles`=0.

## Timing
- OFF entered at rising edge t:
  - `E` falls at the falling edge within cycle t.
  - The high phase following edge t still passes, so the last gated rising edge is t.
- WAKE entered at rising edge w:
  - `E` rises at the falling edge within cycle w.
  - The first restored gated rising edge is w+1.
  - `clk_ready` rises after edge w+WAKE_CYCLES.
- `sleep_req` rises one cycle after the IDLE_CYCLES-th idle sample. It falls on the edge that leaves DRAIN.
- `E` never changes while `CK` is high, so `GCK` never carries a truncated pulse.
- Inputs are sampled at rising edges. `busy` is assumed synchronous to `CK`.

## Configuration
- `CKGATE_CTRL_STATS_EN` defined:
  - `gated_cycles` port exists.
  - It increments on each rising edge where the state is OFF.
  - It saturates at 16'hFFFF and is cleared only by reset.
- `CKGATE_CTRL_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- `ckgate_ctrl_pkg` contains:
  - The state enum typedef (3-bit): RUN=0, IDLE=1, DRAIN=2, OFF=3, WAKE=4.
  - The counter-width helper function.
- Sub-module `ckgate_ctrl_retime` is the falling-edge `E` flop with synchronous active-low set-to-1 reset. It is kept separate for physical-design constraints.

## Test plan
- **Reset:** `RN`=0 for 3 cycles, then release → `E`=1, `clk_ready`=1, `sleep_req`=0, state RUN; `gated_cycles`=0 with stats enabled.
- **Sleep entry:** IDLE_CYCLES=16, `busy`=0 from edge 1, `sleep_ack` echoing `sleep_req` → DRAIN at edge 16, OFF at edge 17, `E`=0 at the falling edge of cycle 17, `clk_ready`=0.
- **Idle abort:** `busy` pulsed at idle sample 10 → state RUN, cnt restarts, `sleep_req` never asserted; 16 further idle samples are needed.
- **Wake:** in OFF, 1-cycle `wake_req` at edge w → `E`=1 at the next falling edge, `clk_ready`=1 after edge w+2 (WAKE_CYCLES=2).
- **Simultaneous abort and ack:** `sleep_ack`=1 and `wake_req`=1 at the same edge in DRAIN → RUN, `E` stays 1 throughout.
- **Forced wake and stats:**
  - `TE`=1 while OFF → WAKE.
  - `RN`=0 while OFF → `E`=1 at the following falling edge.
  - Stats build: 100 OFF cycles → `gated_cycles`=100.
